axi_lite_master: RTL and testbench
==================================

AXI_LITE_MASTER -- requirements
Module: axi_lite_master

Interface
REQ-001 SHALL have parameter PROT, default 3'b000, driven on axi_arprot/axi_awprot.
REQ-002 SHALL have parameter ADDR_W, default 32, address width; data width fixed at 32.
REQ-003 SHALL have ports clk in 1 (sole clock) and rst in 1 (synchronous, active-high reset).
REQ-004 SHALL have ports req_valid in 1, req_ready out 1, req_we in 1, req_addr in ADDR_W, req_wdata in 32, req_wstrb in 4 (core-side request).
REQ-005 SHALL have ports resp_valid out 1, resp_rdata out 32, resp_err out 1 (core-side completion, one-cycle pulse).
REQ-006 SHALL have AXI4-Lite read ports axi_araddr out ADDR_W, axi_arvalid out 1, axi_arready in 1, axi_arprot out 3, axi_rdata in 32, axi_rresp in 2, axi_rvalid in 1, axi_rready out 1.
REQ-007 SHALL have AXI4-Lite write ports axi_awaddr out ADDR_W, axi_awvalid out 1, axi_awready in 1, axi_awprot out 3, axi_wdata out 32, axi_wstrb out 4, axi_wvalid out 1, axi_wready in 1, axi_bresp in 2, axi_bvalid in 1, axi_bready out 1.

Function
REQ-008 SHALL implement FSM states IDLE, AR, R, AW_W, B; exactly one transaction outstanding.
REQ-009 SHALL drive req_ready=1 only in IDLE; a request is accepted on a clk edge with req_valid&req_ready.
REQ-010 SHALL on accept latch req_addr/req_wdata/req_wstrb and go to AR if req_we=0, else AW_W.
REQ-011 SHALL in AR hold axi_arvalid=1 with stable axi_araddr until axi_arready=1, then deassert axi_arvalid next cycle and go to R.
REQ-012 SHALL in R hold axi_rready=1; on axi_rvalid=1 capture axi_rdata to resp_rdata, set resp_err=(axi_rresp!=0), pulse resp_valid next cycle, go to IDLE.
REQ-013 SHALL in AW_W assert axi_awvalid and axi_wvalid together on entry; each SHALL drop independently the cycle after its own handshake; done flags aw_done/w_done track completion in any order, including same-cycle.
REQ-014 SHALL leave AW_W for B only when both aw_done and w_done are set (or both complete that cycle).
REQ-015 SHALL in B hold axi_bready=1; on axi_bvalid=1 set resp_err=(axi_bresp!=0), pulse resp_valid next cycle, go to IDLE; resp_rdata unchanged on writes.
REQ-016 SHALL never deassert a valid, or change its address/data/strobe, before its handshake.
REQ-017 SHALL ignore axi_rvalid outside R and axi_bvalid outside B.
REQ-018 SHALL give minimum latency 3 cycles from accept edge to resp_valid for reads with zero-wait slave (AR, R, resp), and 3 for writes (AW_W, B, resp).
REQ-019 SHALL assert resp_valid for exactly one cycle, coincident with return to IDLE (req_ready=1), allowing back-to-back requests.
REQ-020 SHALL hold axi_araddr/axi_awaddr/axi_wdata/axi_wstrb at last latched value when idle.

Reset
REQ-021 SHALL on rst=1 at a clk edge enter IDLE, clear aw_done/w_done, and drive all valids, readies except req_ready, resp_valid, resp_err to 0; req_ready=1; address, data, strobe and resp_rdata outputs to 0.
REQ-022 SHALL on reset mid-transaction abandon it without emitting resp_valid; the slave is reset by the same rst.

Structure
REQ-023 SHALL place FSM state encoding and AXI response codes (OKAY=2'b00) in a shared package axi_lite_pkg.
REQ-024 SHALL be a single module; no sub-module required.

Verification
REQ-025 Read, zero-wait slave returning 0xDEADBEEF OKAY at addr 0x80000010 -> arvalid one cycle, resp_valid 3 cycles after accept, resp_rdata=0xDEADBEEF, resp_err=0.
REQ-026 Write 0x12345678 strb 4'b0011 addr 0x80000020, awready delayed 3 cycles, wready immediate -> wvalid drops first, awvalid held stable 3 cycles, bready only after both, resp_err=0.
REQ-027 Write with wready delayed 2 cycles after awready, then bresp=2'b10 -> single resp_valid with resp_err=1.
REQ-028 Read with arready low 5 cycles, rvalid delayed 4 cycles, rresp=2'b11 -> araddr stable throughout, resp_err=1, no extra rready after capture.
REQ-029 Back-to-back read then write with req_valid held high -> second request accepted on the resp_valid cycle, no idle gap.
REQ-030 rst asserted in B state with bvalid pending -> no resp_valid, all valids 0 next cycle, req_ready=1.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared types for the AXI4-Lite master: controller states and response codes.
package axi_lite_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AR   = 3'd1,
        ST_R    = 3'd2,
        ST_AW_W = 3'd3,
        ST_B    = 3'd4
    } state_t;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    // Anything other than OKAY is reported to the core as an error.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite master: turns one core request into one AXI
// read or write transaction and returns a one-cycle completion pulse.
module axi_lite_master
    import axi_lite_pkg::*;
#(
    parameter logic [2:0] PROT   = 3'b000,
    parameter int         ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_wstrb,

    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,

    output logic [ADDR_W-1:0] axi_araddr,
    output logic              axi_arvalid,
    input  logic              axi_arready,
    output logic [2:0]        axi_arprot,
    input  logic [31:0]       axi_rdata,
    input  logic [1:0]        axi_rresp,
    input  logic              axi_rvalid,
    output logic              axi_rready,

    output logic [ADDR_W-1:0] axi_awaddr,
    output logic              axi_awvalid,
    input  logic              axi_awready,
    output logic [2:0]        axi_awprot,
    output logic [31:0]       axi_wdata,
    output logic [3:0]        axi_wstrb,
    output logic              axi_wvalid,
    input  logic              axi_wready,
    input  logic [1:0]        axi_bresp,
    input  logic              axi_bvalid,
    output logic              axi_bready
);

    state_t            state_q, state_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              resp_err_q, resp_err_d;
    logic              resp_valid_q, resp_valid_d;
    logic              aw_hs, w_hs;

    // Handshake strobes are decoded straight from state so every valid/ready
    // changes exactly one edge after the event that moves it.
    assign req_ready   = (state_q == ST_IDLE);
    assign axi_arvalid = (state_q == ST_AR);
    assign axi_rready  = (state_q == ST_R);
    assign axi_awvalid = (state_q == ST_AW_W) && !aw_done_q;
    assign axi_wvalid  = (state_q == ST_AW_W) && !w_done_q;
    assign axi_bready  = (state_q == ST_B);

    assign axi_araddr  = addr_q;
    assign axi_awaddr  = addr_q;
    assign axi_wdata   = wdata_q;
    assign axi_wstrb   = wstrb_q;
    assign axi_arprot  = PROT;
    assign axi_awprot  = PROT;

    assign resp_valid  = resp_valid_q;
    assign resp_rdata  = rdata_q;
    assign resp_err    = resp_err_q;

    assign aw_hs = axi_awvalid && axi_awready;
    assign w_hs  = axi_wvalid && axi_wready;

    always_comb begin
        state_d      = state_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        rdata_d      = rdata_q;
        resp_err_d   = resp_err_q;
        resp_valid_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    wstrb_d = req_wstrb;
                    state_d = req_we ? ST_AW_W : ST_AR;
                end
            end
            ST_AR: begin
                if (axi_arready) begin
                    state_d = ST_R;
                end
            end
            ST_R: begin
                if (axi_rvalid) begin
                    rdata_d      = axi_rdata;
                    resp_err_d   = resp_is_err(axi_rresp);
                    resp_valid_d = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            ST_AW_W: begin
                // Address and data channels complete independently, in either order.
                aw_done_d = aw_done_q || aw_hs;
                w_done_d  = w_done_q || w_hs;
                if (aw_done_d && w_done_d) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = ST_B;
                end
            end
            ST_B: begin
                if (axi_bvalid) begin
                    resp_err_d   = resp_is_err(axi_bresp);
                    resp_valid_d = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            rdata_q      <= '0;
            resp_err_q   <= 1'b0;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            rdata_q      <= rdata_d;
            resp_err_q   <= resp_err_d;
            resp_valid_q <= resp_valid_d;
        end
    end

endmodule

// File: tb/tb_axi_lite_master.sv
// Randomized bench for axi_lite_master: a cycle-timed slave plus a
// transaction-level model predicting every output from the channel wait counts.
module tb_axi_lite_master;

    logic        clk;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] axi_araddr, axi_awaddr, axi_rdata, axi_wdata;
    logic        axi_arvalid, axi_arready, axi_rvalid, axi_rready;
    logic        axi_awvalid, axi_awready, axi_wvalid, axi_wready;
    logic        axi_bvalid, axi_bready;
    logic [2:0]  axi_arprot, axi_awprot;
    logic [1:0]  axi_rresp, axi_bresp;
    logic [3:0]  axi_wstrb;

    axi_lite_master #(.PROT(3'b000), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_arprot(axi_arprot), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
        .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_awprot(axi_awprot), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_bresp(axi_bresp),
        .axi_bvalid(axi_bvalid), .axi_bready(axi_bready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          ar_w, r_w, aw_w, w_w, b_w;
        logic [1:0]  resp;
        logic [31:0] rdata;
        bit          rst_in_b;
        int          gap;
    } txn_t;

    txn_t        q[$];
    txn_t        cur;
    int          acc_log[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          acc = 0;
    int          idle_cnt = 0;
    int          rst_left = 0;
    int          ntx = 0;
    bit          busy = 0;
    bit          rst_prev = 0;
    logic [31:0] m_addr = 0, m_wdata = 0, m_rdata = 0;
    logic [3:0]  m_strb = 0;
    logic        m_err = 0;
    int          obs_ar, obs_rr, obs_aw, obs_w, obs_br, obs_resp_cnt, obs_lat;
    logic [31:0] obs_rdata;
    logic        obs_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    function automatic txn_t mk(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] strb, input int ar_w, input int r_w,
                                input int aw_w, input int w_w, input int b_w,
                                input logic [1:0] resp, input logic [31:0] rdata,
                                input bit rst_in_b, input int gap);
        txn_t t;
        t.we = we; t.addr = addr; t.wdata = wdata; t.strb = strb;
        t.ar_w = ar_w; t.r_w = r_w; t.aw_w = aw_w; t.w_w = w_w; t.b_w = b_w;
        t.resp = resp; t.rdata = rdata; t.rst_in_b = rst_in_b; t.gap = gap;
        return t;
    endfunction

    // One clock cycle: compare outputs against the model, then drive the next edge.
    task automatic step();
        int rel, mx, done_rel;
        bit arv_e, rr_e, awv_e, wv_e, br_e, resp_e, was_busy, drive_rst;
        @(negedge clk);
        rel = cyc - acc;
        mx = (cur.aw_w > cur.w_w) ? cur.aw_w : cur.w_w;
        done_rel = -1;
        arv_e = 0; rr_e = 0; awv_e = 0; wv_e = 0; br_e = 0; resp_e = 0;
        was_busy = busy;
        if (busy) begin
            if (!cur.we) begin
                arv_e = (rel >= 1) && (rel <= 1 + cur.ar_w);
                rr_e = (rel >= cur.ar_w + 2) && (rel <= cur.ar_w + 2 + cur.r_w);
                done_rel = cur.ar_w + cur.r_w + 3;
            end else begin
                awv_e = (rel >= 1) && (rel <= 1 + cur.aw_w);
                wv_e = (rel >= 1) && (rel <= 1 + cur.w_w);
                br_e = (rel >= mx + 2) && (rel <= mx + 2 + cur.b_w);
                done_rel = mx + cur.b_w + 3;
            end
            resp_e = (rel == done_rel);
            if (resp_e) begin
                if (!cur.we) m_rdata = cur.rdata;
                m_err = (cur.resp != 2'b00);
            end
        end

        chk("req_ready", 32'(req_ready), 32'(!busy || resp_e));
        chk("resp_valid", 32'(resp_valid), 32'(resp_e));
        chk("arvalid", 32'(axi_arvalid), 32'(arv_e));
        chk("rready", 32'(axi_rready), 32'(rr_e));
        chk("awvalid", 32'(axi_awvalid), 32'(awv_e));
        chk("wvalid", 32'(axi_wvalid), 32'(wv_e));
        chk("bready", 32'(axi_bready), 32'(br_e));
        chk("araddr", axi_araddr, m_addr);
        chk("awaddr", axi_awaddr, m_addr);
        chk("wdata", axi_wdata, m_wdata);
        chk("wstrb", 32'(axi_wstrb), 32'(m_strb));
        chk("prot", 32'({axi_arprot, axi_awprot}), 32'd0);
        chk("resp_rdata", resp_rdata, m_rdata);
        if (resp_e || rst_prev) chk("resp_err", 32'(resp_err), 32'(m_err));

        if (axi_arvalid) obs_ar++;
        if (axi_rready) obs_rr++;
        if (axi_awvalid) obs_aw++;
        if (axi_wvalid) obs_w++;
        if (axi_bready) obs_br++;
        if (resp_valid) begin
            obs_resp_cnt++;
            obs_lat = rel;
            obs_rdata = resp_rdata;
            obs_err = resp_err;
        end
        if (resp_e) begin
            $display("txn %0d %s addr=%h lat=%0d err=%0b rdata=%h", ntx,
                     cur.we ? "WR" : "RD", cur.addr, rel, resp_err, resp_rdata);
            ntx++;
            busy = 0;
        end

        drive_rst = 0;
        if (rst_left > 0) begin
            drive_rst = 1;
            rst_left--;
        end
        if (was_busy && !resp_e && cur.we && cur.rst_in_b && rel == mx + 2 + cur.b_w)
            drive_rst = 1;

        axi_arready = arv_e ? (rel == 1 + cur.ar_w) : 1'($urandom);
        axi_rvalid  = rr_e ? (rel == cur.ar_w + 2 + cur.r_w) : 1'($urandom);
        axi_rdata   = (rr_e && axi_rvalid) ? cur.rdata : $urandom;
        axi_rresp   = (rr_e && axi_rvalid) ? cur.resp : 2'($urandom);
        axi_awready = awv_e ? (rel == 1 + cur.aw_w) : 1'($urandom);
        axi_wready  = wv_e ? (rel == 1 + cur.w_w) : 1'($urandom);
        axi_bvalid  = br_e ? (rel == mx + 2 + cur.b_w) : 1'($urandom);
        axi_bresp   = (br_e && axi_bvalid) ? cur.resp : 2'($urandom);

        req_we = 1'($urandom);
        req_addr = $urandom;
        req_wdata = $urandom;
        req_wstrb = 4'($urandom);
        rst_prev = 0;
        if (drive_rst) begin
            rst = 1'b1;
            req_valid = 1'($urandom);
            if (was_busy && !resp_e) begin
                $display("txn %0d %s addr=%h abandoned by reset", ntx, cur.we ? "WR" : "RD", cur.addr);
                ntx++;
            end
            busy = 0;
            m_addr = 0; m_wdata = 0; m_strb = 0; m_rdata = 0; m_err = 0;
            rst_prev = 1;
        end else begin
            rst = 1'b0;
            if (busy) begin
                req_valid = 1'($urandom);
            end else if (q.size() != 0 && idle_cnt >= q[0].gap) begin
                cur = q.pop_front();
                req_valid = 1'b1;
                req_we = cur.we;
                req_addr = cur.addr;
                req_wdata = cur.wdata;
                req_wstrb = cur.strb;
                busy = 1;
                acc = cyc;
                acc_log.push_back(cyc);
                idle_cnt = 0;
                m_addr = cur.addr; m_wdata = cur.wdata; m_strb = cur.strb;
                obs_ar = 0; obs_rr = 0; obs_aw = 0; obs_w = 0; obs_br = 0;
                obs_resp_cnt = 0; obs_lat = -1; obs_rdata = 0; obs_err = 0;
            end else begin
                req_valid = 1'b0;
                idle_cnt++;
            end
        end
        cyc++;
    endtask

    task automatic run_all();
        int guard = 0;
        while ((busy || q.size() != 0) && guard < 5000) begin
            step();
            guard++;
        end
        if (guard >= 5000) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout cyc=%0d actual=busy required=idle", cyc);
        end
        repeat (2) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0;
        axi_arready = 0; axi_rvalid = 0; axi_rdata = 0; axi_rresp = 0;
        axi_awready = 0; axi_wready = 0; axi_bvalid = 0; axi_bresp = 0;
        obs_ar = 0; obs_rr = 0; obs_aw = 0; obs_w = 0; obs_br = 0;
        obs_resp_cnt = 0; obs_lat = -1; obs_rdata = 0; obs_err = 0;
        repeat (2) @(negedge clk);
        rst_prev = 1;
        rst_left = 1;
        repeat (3) step();

        // Zero-wait read
        q.push_back(mk(0, 32'h80000010, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b00, 32'hDEADBEEF, 0, 0));
        run_all();
        chk("rd0_latency", 32'(obs_lat), 32'd3);
        chk("rd0_rdata", obs_rdata, 32'hDEADBEEF);
        chk("rd0_err", 32'(obs_err), 32'd0);
        chk("rd0_arvalid_cycles", 32'(obs_ar), 32'd1);

        // Write, awready 3 cycles late, wready immediate
        q.push_back(mk(1, 32'h80000020, 32'h12345678, 4'b0011, 0, 0, 3, 0, 0, 2'b00, 32'h0, 0, 0));
        run_all();
        chk("wr_aw_late_awvalid_cycles", 32'(obs_aw), 32'd4);
        chk("wr_aw_late_wvalid_cycles", 32'(obs_w), 32'd1);
        chk("wr_aw_late_bready_cycles", 32'(obs_br), 32'd1);
        chk("wr_aw_late_latency", 32'(obs_lat), 32'd6);
        chk("wr_aw_late_err", 32'(obs_err), 32'd0);

        // Write, wready 2 cycles after awready, SLVERR
        q.push_back(mk(1, 32'h00001000, 32'hA5A5A5A5, 4'hF, 0, 0, 0, 2, 1, 2'b10, 32'h0, 0, 0));
        run_all();
        chk("wr_slverr_resp_count", 32'(obs_resp_cnt), 32'd1);
        chk("wr_slverr_err", 32'(obs_err), 32'd1);
        chk("wr_slverr_latency", 32'(obs_lat), 32'd6);
        chk("wr_slverr_rdata_kept", obs_rdata, 32'hDEADBEEF);

        // Slow read with DECERR
        q.push_back(mk(0, 32'h40000004, 32'h0, 4'h0, 5, 4, 0, 0, 0, 2'b11, 32'hCAFEF00D, 0, 1));
        run_all();
        chk("rd_slow_arvalid_cycles", 32'(obs_ar), 32'd6);
        chk("rd_slow_rready_cycles", 32'(obs_rr), 32'd5);
        chk("rd_slow_latency", 32'(obs_lat), 32'd12);
        chk("rd_slow_err", 32'(obs_err), 32'd1);
        chk("rd_slow_rdata", obs_rdata, 32'hCAFEF00D);

        // Back-to-back read then write
        acc_log.delete();
        q.push_back(mk(0, 32'h00000100, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b00, 32'h11112222, 0, 0));
        q.push_back(mk(1, 32'h00000104, 32'h33334444, 4'hC, 0, 0, 0, 0, 0, 2'b00, 32'h0, 0, 0));
        run_all();
        chk("b2b_accept_spacing", 32'(acc_log[1] - acc_log[0]), 32'd3);

        // Reset while in B with bvalid presented
        q.push_back(mk(1, 32'h00000200, 32'h55AA55AA, 4'hF, 1, 0, 0, 1, 2, 2'b00, 32'h0, 1, 0));
        run_all();
        chk("rst_in_b_no_resp", 32'(obs_resp_cnt), 32'd0);
        chk("rst_in_b_req_ready", 32'(req_ready), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 60; i++) begin
            q.push_back(mk(1'($urandom), $urandom, $urandom, 4'($urandom),
                           $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
                           $urandom_range(0, 4), $urandom_range(0, 3),
                           ($urandom_range(0, 1) == 1) ? 2'b00 : 2'($urandom),
                           $urandom, 0, $urandom_range(0, 2)));
        end
        run_all();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
